// File: rtl/clk_tick_scheduler_pkg.sv
// rtl/clk_tick_scheduler_pkg.sv - shared types and constants for the tick scheduler
package tick_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } tick_sched_state_t;

    localparam int TICK_SCHED_MIN_PRESCALE = 2;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/clk_tick_scheduler_if.sv
// rtl/clk_tick_scheduler_if.sv - configuration request port of the tick scheduler
interface clk_tick_scheduler_if #(
    parameter int N_CH  = 4,
    parameter int DIV_W = 16
);
    localparam int CH_W = tick_sched_pkg::ch_width(N_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_en;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_en,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_en,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_tick_scheduler_channel.sv
// rtl/clk_tick_scheduler_channel.sv - one divide-by-div enable-tick channel
module tick_channel #(
    parameter int DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             base_tick,
    input  logic             load,
    input  logic             clear,
    input  logic [DIV_W-1:0] load_div,
    input  logic             load_en,
    output logic             tick
);

    logic             en_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    // load and clear only arrive on base-tick edges, and both suppress the tick there
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            en_q  <= 1'b0;
            div_q <= '0;
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                div_q <= load_div;
                en_q  <= load_en;
                cnt_q <= '0;
            end else if (clear) begin
                cnt_q <= '0;
            end else if (base_tick && en_q && (div_q != '0)) begin
                if (cnt_q == div_q - DIV_W'(1)) begin
                    tick  <= 1'b1;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/clk_tick_scheduler.sv
// rtl/clk_tick_scheduler.sv - shared-prescaler tick scheduler; TICK_SCHED_PHASE_ALIGN_EN realigns all channels on commit
module clk_tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int PRESCALE = 100,
    parameter int DIV_W    = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    clk_tick_scheduler_if.slave  cfg,
    output logic                 base_tick,
    output logic [N_CH-1:0]      tick_out
);

    localparam int CH_W = ch_width(N_CH);
    localparam int PRE  = (PRESCALE < TICK_SCHED_MIN_PRESCALE) ? TICK_SCHED_MIN_PRESCALE : PRESCALE;
    localparam int P_W  = $clog2(PRE);
    localparam logic [P_W-1:0]  P_LAST = P_W'(PRE - 1);
    localparam logic [CH_W:0]   N_CH_L = (CH_W + 1)'(N_CH);

    logic [P_W-1:0]    p_q;
    logic              bt_edge;
    logic              base_tick_q;

    tick_sched_state_t state_q, state_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              cfg_err_q;
    logic              hs;
    logic              commit, ch_ok, commit_bad, clear_all;
    logic [N_CH-1:0]   load_vec;

    logic [CH_W-1:0]   sh_ch_q;
    logic [DIV_W-1:0]  sh_div_q;
    logic              sh_en_q;

    // bt_edge marks the clock edge on which base_tick and channel ticks get set
    assign bt_edge = (p_q == P_LAST);

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            p_q         <= '0;
            base_tick_q <= 1'b0;
        end else begin
            p_q         <= bt_edge ? '0 : p_q + P_W'(1);
            base_tick_q <= bt_edge;
        end
    end

    assign hs = (state_q == ST_IDLE) && cfg.cfg_valid && cfg_ready_q;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= commit_bad;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (hs)      state_d = ST_WAIT;
            ST_WAIT: if (bt_edge) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        commit      = (state_q == ST_WAIT) && bt_edge;
        ch_ok       = ({1'b0, sh_ch_q} < N_CH_L);
        commit_bad  = commit && !ch_ok;
        cfg_ready_d = (state_d == ST_IDLE);
        load_vec    = '0;
        for (int i = 0; i < N_CH; i++) begin
            load_vec[i] = commit && ch_ok && (sh_ch_q == CH_W'(i));
        end
`ifdef TICK_SCHED_PHASE_ALIGN_EN
        clear_all   = commit;
`else
        clear_all   = 1'b0;
`endif
    end

    // Shadow holds the accepted request until the next base tick; reset drops it.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            sh_ch_q  <= '0;
            sh_div_q <= '0;
            sh_en_q  <= 1'b0;
        end else if (hs) begin
            sh_ch_q  <= cfg.cfg_ch;
            sh_div_q <= cfg.cfg_div;
            sh_en_q  <= cfg.cfg_en;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_channel #(.DIV_W(DIV_W)) u_ch (
            .clk_in    (clk_in),
            .reset     (reset),
            .base_tick (bt_edge),
            .load      (load_vec[i]),
            .clear     (clear_all),
            .load_div  (sh_div_q),
            .load_en   (sh_en_q),
            .tick      (tick_out[i])
        );
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign base_tick     = base_tick_q;

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// tb/tb_clk_tick_scheduler.sv - scoreboard bench for clk_tick_scheduler against an edge-arithmetic model
module tb_clk_tick_scheduler;

    localparam int N  = 3;
    localparam int P  = 4;
    localparam int DW = 8;
    localparam int CW = tick_sched_pkg::ch_width(N);

    logic          clk_in = 1'b0;
    logic          reset  = 1'b0;
    logic          base_tick;
    logic [N-1:0]  tick_out;

    clk_tick_scheduler_if #(.N_CH(N), .DIV_W(DW)) cfg_if ();

    clk_tick_scheduler #(.N_CH(N), .PRESCALE(P), .DIV_W(DW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .cfg       (cfg_if.slave),
        .base_tick (base_tick),
        .tick_out  (tick_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int           at;
        bit           base;
        bit [N-1:0]   tick;
        bit           err;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Model: edge count since reset release, pending request, per-channel phase anchor.
    int  n = 0;
    bit  pend = 1'b0;
    int  commit_at = 0;
    int  sh_ch = 0, sh_div = 0;
    bit  sh_en = 1'b0;
    bit  m_ready = 1'b0;
    bit  hs_seen = 1'b0;
    bit  m_en[N];
    int  m_div[N];
    int  m_anchor[N];

    function automatic void model_step();
        ev_t e;
        hs_seen = 1'b0;
        if (!reset) begin
            n = 0; pend = 1'b0; m_ready = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_en[i] = 1'b0; m_div[i] = 0; m_anchor[i] = 0;
            end
            return;
        end
        n++;
        e.at = n; e.base = (n % P == 0); e.tick = '0; e.err = 1'b0;
        if (pend && n == commit_at) begin
            pend = 1'b0;
`ifdef TICK_SCHED_PHASE_ALIGN_EN
            for (int i = 0; i < N; i++) m_anchor[i] = n;
`endif
            if (sh_ch < N) begin
                m_en[sh_ch] = sh_en; m_div[sh_ch] = sh_div; m_anchor[sh_ch] = n;
            end else begin
                e.err = 1'b1;
            end
        end else if (cfg_if.cfg_valid && m_ready) begin
            pend      = 1'b1;
            commit_at = (n / P + 1) * P;
            sh_ch     = int'(cfg_if.cfg_ch);
            sh_div    = int'(cfg_if.cfg_div);
            sh_en     = cfg_if.cfg_en;
            hs_seen   = 1'b1;
        end
        m_ready = !pend;
        for (int i = 0; i < N; i++) begin
            if (m_en[i] && m_div[i] != 0 && n > m_anchor[i] && ((n - m_anchor[i]) % (m_div[i] * P)) == 0)
                e.tick[i] = 1'b1;
        end
        if (e.base || e.tick != '0 || e.err) exp_q.push_back(e);
    endfunction

    task automatic step_clk();
        @(posedge clk_in);
        model_step();
        #1;
    endtask

    task automatic do_cfg(input int ch, input int dv, input bit en);
        int k = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = CW'(ch);
        cfg_if.cfg_div   = DW'(dv);
        cfg_if.cfg_en    = en;
        do begin
            step_clk();
            k++;
        end while (!hs_seen && k < 50);
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (!hs_seen) begin
            errors++;
            $display("FAIL cfg_handshake ch%0d: no acceptance within %0d cycles", ch, k);
        end
    endtask

    task automatic wait_commit();
        int k = 0;
        while (pend && k < 20) begin
            step_clk();
            k++;
        end
        checks++;
        if (pend) begin
            errors++;
            $display("FAIL commit_timeout: request still pending after %0d cycles", k);
        end
    endtask

    always @(negedge clk_in) begin
        ev_t e;
        checks++;
        if (cfg_if.cfg_ready !== m_ready) begin
            errors++;
            $display("FAIL cfg_ready edge %0d: got %b want %b", n, cfg_if.cfg_ready, m_ready);
        end
        if (base_tick !== 1'b0 || tick_out !== '0 || cfg_if.cfg_err !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output edge %0d: base=%b tick=%b err=%b, none expected",
                         n, base_tick, tick_out, cfg_if.cfg_err);
            end else begin
                e = exp_q.pop_front();
                if (e.at != n || e.base !== base_tick || e.tick !== tick_out || e.err !== cfg_if.cfg_err) begin
                    errors++;
                    $display("FAIL output_event: got edge %0d base=%b tick=%b err=%b want edge %0d base=%b tick=%b err=%b",
                             n, base_tick, tick_out, cfg_if.cfg_err, e.at, e.base, e.tick, e.err);
                end
            end
        end
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
        cfg_if.cfg_en    = 1'b0;

        repeat (3) step_clk();
        reset = 1'b1;
        repeat (10) step_clk();

        do_cfg(0, 3, 1'b1); wait_commit();
        repeat (40) step_clk();

        do_cfg(1, 1, 1'b1); wait_commit();
        do_cfg(2, 0, 1'b1); wait_commit();
        repeat (30) step_clk();

        do_cfg(3, 5, 1'b1); wait_commit();
        repeat (20) step_clk();

        do_cfg(1, 3, 1'b1); wait_commit();
        repeat (40) step_clk();

        do_cfg(0, 1, 1'b1);
        reset = 1'b0;
        repeat (2) step_clk();
        reset = 1'b1;
        repeat (30) step_clk();

        for (int c = 0; c < 600; c++) begin
            cfg_if.cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_if.cfg_ch    = CW'($urandom_range(0, 3));
            cfg_if.cfg_div   = DW'($urandom_range(0, 4));
            cfg_if.cfg_en    = ($urandom_range(0, 3) != 0);
            reset            = ($urandom_range(0, 199) != 0);
            step_clk();
        end
        cfg_if.cfg_valid = 1'b0;
        reset = 1'b1;
        repeat (20) step_clk();

        @(negedge clk_in);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: %0d expected outputs never seen, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_tick_scheduler.md
# clk_tick_scheduler

Shares one free-running prescaler among N_CH enable-tick channels. Each channel has a programmable divide ratio and emits single-cycle `tick_out` pulses. Channels are reconfigured through a valid/ready port, with commits aligned to the base tick. Sits beside the clock divider and replaces per-consumer derived clocks with clock enables on `clk_in`.

## Interface
- `N_CH`, default 4: number of tick channels, 1..16.
- `PRESCALE`, default 100: `clk_in` cycles per base tick; must be ≥ 2.
- `DIV_W`, default 16: width of each channel divide ratio.
- `clk_in` input, 1 bit: sole clock; all logic on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset.
- `cfg_valid` input, 1 bit: configuration request.
- `cfg_ready` output, 1 bit: scheduler accepts a request.
- `cfg_ch` input, `$clog2(N_CH)` bits (min 1): target channel.
- `cfg_div` input, `DIV_W` bits: divide ratio; 0 means no ticks.
- `cfg_en` input, 1 bit: channel enable.
- `cfg_err` output, 1 bit: one-cycle pulse when a commit targets `cfg_ch ≥ N_CH`.
- `base_tick` output, 1 bit: one-cycle pulse every `PRESCALE` cycles.
- `tick_out` output, `N_CH` bits: per-channel one-cycle tick pulses.

## Operation
- Prescaler `p` counts 0..PRESCALE-1, then wraps to 0.
- At the edge where `p == PRESCALE-1`, `base_tick` is set to 1; on every other edge it is set to 0.
- Channel state: `en`, `div`, counter `cnt`. Each register is `DIV_W` bits where applicable.
- At each base-tick edge, for each enabled channel with `div ≠ 0`:
  - if `cnt == div-1`: set `tick_out[i]` to 1 and clear `cnt`;
  - otherwise: increment `cnt`.
- `tick_out[i]` is 0 on all other edges.
- A disabled channel, or one with `div == 0`, holds `cnt` and never ticks.
- FSM states:
  - ST_IDLE: `cfg_ready` = 1. On `cfg_valid & cfg_ready`, capture `cfg_ch`, `cfg_div` and `cfg_en` into a shadow register and go to ST_WAIT.
  - ST_WAIT: `cfg_ready` = 0; inputs are ignored. At the next base-tick edge, commit the shadow and return to ST_IDLE.
- Commit to a valid channel: load `div` and `en`, clear `cnt`, and force `tick_out[ch]` to 0 for that base tick. Other channels update normally.
- Commit to `cfg_ch ≥ N_CH`: no channel changes; `cfg_err` is pulsed at the commit edge.
- Reset values:
  - outputs: `cfg_ready` 0, `cfg_err` 0, `base_tick` 0, `tick_out` all 0;
  - internal: `p` 0, all `en` 0, all `div` 0, all `cnt` 0, FSM in ST_IDLE.
- Reset asserted mid-operation, including in ST_WAIT, discards the pending shadow and disables every channel.

## Timing
- `cfg_ready` is registered. It rises on the first edge with `reset` high.
- `cfg_ready` falls on the handshake edge and rises again on the commit edge. The next request can be accepted in the cycle after the commit.
- The first `base_tick` occurs on the PRESCALE-th edge after reset release.
- `tick_out[i]` is coincident with `base_tick`.
- Steady-state tick period is `PRESCALE × div` cycles.
- The first tick after a commit comes `div` base ticks after the commit edge.
- Handshake-to-commit latency is 1 to PRESCALE cycles.
- A handshake on the same edge as a base tick commits at the following base tick, not the current one.

## Configuration
- Macro: `TICK_SCHED_PHASE_ALIGN_EN`.
- Defined: every commit clears `cnt` of all channels. Enabled channels with equal `div` then tick in the same cycle.
- Undefined: only the target channel's `cnt` is cleared; other channels keep their phase.

## Structure
- Package `tick_sched_pkg` holds:
  - the state typedef `tick_sched_state_t` (ST_IDLE, ST_WAIT);
  - the constant `TICK_SCHED_MIN_PRESCALE` = 2.
- Sub-module `tick_channel` holds `en`, `div` and `cnt` plus the tick logic, with a `base_tick` input, a load strobe and a clear strobe. It is instantiated N_CH times in a generate loop.

## Test plan
Bench parameters: `PRESCALE` = 4, `DIV_W` = 8.
- Reset:
  - Stimulus: hold `reset` low 3 cycles, then release.
  - Required: all outputs 0 while in reset; `cfg_ready` = 1 on the first edge after release; `base_tick` pulses on edges 4, 8, 12, …
- Basic divide:
  - Stimulus: configure ch0 with div = 3, en = 1.
  - Required: `cfg_ready` low until the commit; `tick_out[0]` pulses every 12 cycles, first at commit + 12.
- Boundary ratios:
  - Stimulus: ch1 with div = 1; ch2 with div = 0, en = 1.
  - Required: `tick_out[1]` equals `base_tick` every period; `tick_out[2]` stays 0.
- Invalid channel:
  - Stimulus: `N_CH` = 3, `cfg_ch` = 3.
  - Required: one `cfg_err` pulse at the commit edge; channel states unchanged.
- Reset in ST_WAIT:
  - Stimulus: assert `reset` while in ST_WAIT.
  - Required: no commit occurs; after release every `tick_out` stays 0.
- Phase align:
  - Stimulus: ch0 running with div = 3; commit ch1 with div = 3.
  - Required with `TICK_SCHED_PHASE_ALIGN_EN`: ticks coincide.
  - Required without it: ch0 keeps its original phase.
